// File: rtl/mul_unit.sv
// Iterative 64-bit shift-add multiplier (MUL / UMULH / SMULH) with Busy/Done handshake.
// Define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module mul_unit #(
  parameter int WIDTH = 64,
  parameter int CNTW  = 7
) (
  input  logic             Clk,
  input  logic             ResetL,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic [4:0]       DestIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [4:0]       DestOut
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [1:0] OP_UMULH = 2'b01;
  localparam logic [1:0] OP_SMULH = 2'b10;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   ma_q, ma_d, p_q, p_d;
  logic [WIDTH-1:0]     mb_q, mb_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [1:0]           op_q, op_d;
  logic [4:0]           dest_q, dest_d, destout_q, destout_d;
  logic [WIDTH-1:0]     res_q, res_d;

  logic                 is_s, last;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [2*WIDTH-1:0]   p_sum, fin;

  assign is_s  = (Op == OP_SMULH);
  assign abs_a = (is_s && OpA[WIDTH-1]) ? (~OpA + WIDTH'(1)) : OpA;
  assign abs_b = (is_s && OpB[WIDTH-1]) ? (~OpB + WIDTH'(1)) : OpB;
  assign p_sum = p_q + (mb_q[0] ? ma_q : '0);
  assign fin   = neg_q ? (~p_sum + (2*WIDTH)'(1)) : p_sum;

`ifdef MUL_EARLY_EXIT_EN
  // Once the bits above MB[0] are clear, this edge's add is the last one that matters.
  assign last = (cnt_q == CNTW'(WIDTH-1)) || (mb_q[WIDTH-1:1] == '0);
`else
  assign last = (cnt_q == CNTW'(WIDTH-1));
`endif

  always_comb begin
    state_d   = state_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    op_d      = op_q;
    dest_d    = dest_q;
    res_d     = res_q;
    destout_d = destout_q;
    case (state_q)
      IDLE:    if (Start) state_d = CALC;
      CALC:    if (last)  state_d = DONE;
      DONE:    state_d = Start ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
    if (Start && state_q != CALC) begin
      ma_d   = {{WIDTH{1'b0}}, abs_a};
      mb_d   = abs_b;
      p_d    = '0;
      cnt_d  = '0;
      neg_d  = is_s && (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
      op_d   = Op;
      dest_d = DestIn;
    end else if (state_q == CALC) begin
      p_d   = p_sum;
      ma_d  = ma_q << 1;
      mb_d  = mb_q >> 1;
      cnt_d = cnt_q + CNTW'(1);
      if (last) begin
        res_d     = (op_q == OP_UMULH || op_q == OP_SMULH) ? fin[2*WIDTH-1:WIDTH]
                                                         : fin[WIDTH-1:0];
        destout_d = dest_q;
      end
    end
  end

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      ma_q      <= '0;
      mb_q      <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      op_q      <= '0;
      dest_q    <= '0;
      res_q     <= '0;
      destout_q <= '0;
    end else begin
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      op_q      <= op_d;
      dest_q    <= dest_d;
      res_q     <= res_d;
      destout_q <= destout_d;
    end
  end

  assign Busy    = (state_q == CALC);
  assign Done    = (state_q == DONE);
  assign Result  = res_q;
  assign DestOut = destout_q;

endmodule
